// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port register file.
package rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    localparam int unsigned ZERO_REG = 0;

    typedef logic [DEF_ADDR_W-1:0] rf_addr_t;
    typedef logic [DEF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: decode, register-0 and reset overrides.
// Optional same-cycle write-to-read bypass when RF_BYPASS_EN is defined.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
`ifdef RF_BYPASS_EN
    ,
    parameter int NUM_WR = 2
`endif
) (
    input  logic                                 reset,
    input  logic [ADDR_W-1:0]                    rd_addr,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   regs,
    input  logic [(2**ADDR_W)-1:0]               pending,
`ifdef RF_BYPASS_EN
    input  logic [NUM_WR-1:0]                    wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]             wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]             wr_data,
    input  logic                                 claim_en,
    input  logic [ADDR_W-1:0]                    claim_addr,
`endif
    output logic [DATA_W-1:0]                    rd_data,
    output logic                                 rd_busy
);

    always_comb begin
        rd_data = regs[rd_addr];
        rd_busy = pending[rd_addr];
`ifdef RF_BYPASS_EN
        // Ascending scan so the youngest (highest-index) matching port wins.
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == rd_addr)) begin
                rd_data = wr_data[p*DATA_W +: DATA_W];
                rd_busy = claim_en && (claim_addr == rd_addr);
            end
        end
`endif
        if (reset || (rd_addr == ADDR_W'(ZERO_REG))) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// Multi-port register file with per-register pending (scoreboard) bits.
// Define RF_BYPASS_EN to compile in the same-cycle write-to-read bypass.
module multiport_register_file
    import rf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             pending_q, pending_d;

    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        // Later ports overwrite earlier ones, giving the younger result priority.
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))) begin
                regs_d[wr_addr[p*ADDR_W +: ADDR_W]]    = wr_data[p*DATA_W +: DATA_W];
                pending_d[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        // A claim issued alongside writeback of the same register keeps it busy.
        if (claim_en && (claim_addr != ADDR_W'(ZERO_REG))) begin
            pending_d[claim_addr] = 1'b1;
        end
        regs_d[ZERO_REG]    = '0;
        pending_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q    <= '0;
            pending_q <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
        end
    end

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
`ifdef RF_BYPASS_EN
            ,
            .NUM_WR (NUM_WR)
`endif
        ) u_rd (
            .reset      (reset),
            .rd_addr    (rd_addr[r*ADDR_W +: ADDR_W]),
            .regs       (regs_q),
            .pending    (pending_q),
`ifdef RF_BYPASS_EN
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .claim_en   (claim_en),
            .claim_addr (claim_addr),
`endif
            .rd_data    (rd_data[r*DATA_W +: DATA_W]),
            .rd_busy    (rd_busy[r])
        );
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file (default 32x32, 2R/2W).
module tb_multiport_register_file;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic             claim_en;
    logic [4:0]       claim_addr;
    logic [1:0][4:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic [1:0]       rd_busy;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] m_regs [32];
    logic        m_pend [32];

    multiport_register_file dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy)
    );

    always #5 clk = ~clk;

    // Expected read value from the architectural state and current inputs.
    function automatic logic [31:0] exp_data(int r);
        logic [4:0] a;
        a = rd_addr[r];
        if (reset || a == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (wr_en[1] && wr_addr[1] == a) return wr_data[1];
        if (wr_en[0] && wr_addr[0] == a) return wr_data[0];
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(int r);
        logic [4:0] a;
        a = rd_addr[r];
        if (reset || a == 5'd0) return 1'b0;
`ifdef RF_BYPASS_EN
        if ((wr_en[1] && wr_addr[1] == a) || (wr_en[0] && wr_addr[0] == a))
            return claim_en && claim_addr == a;
`endif
        return m_pend[a];
    endfunction

    task automatic idle();
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
    endtask

    // Advance the reference state by one edge using the inputs now applied.
    task automatic tick();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_pend[i] = 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++)
                if (wr_en[p] && wr_addr[p] != 5'd0) begin
                    m_regs[wr_addr[p]] = wr_data[p];
                    m_pend[wr_addr[p]] = 1'b0;
                end
            if (claim_en && claim_addr != 5'd0) m_pend[claim_addr] = 1'b1;
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wr_en   = 2'b11;
            wr_addr = {5'($urandom_range(1, 31)), 5'($urandom_range(1, 31))};
            wr_data = {$urandom, $urandom};
            rd_addr = wr_addr;
            #1;
            for (int r = 0; r < 2; r++) begin
                n_cmp++;
                if (rd_data[r] !== 32'h0 || rd_busy[r] !== 1'b0) begin
                    n_mis++;
                    $display("FAIL reset_forced port%0d data %h busy %b, need 0/0", r, rd_data[r], rd_busy[r]);
                end
            end
            tick();
        end
        @(negedge clk);
        reset = 1'b0;
        idle();
        for (int a = 0; a < 32; a += 2) begin
            rd_addr[0] = 5'(a);
            rd_addr[1] = 5'(a + 1);
            #1;
            for (int r = 0; r < 2; r++) begin
                n_cmp++;
                if (rd_data[r] !== 32'h0 || rd_busy[r] !== 1'b0) begin
                    n_mis++;
                    $display("FAIL reset_clear addr %0d data %h busy %b, need 0/0", rd_addr[r], rd_data[r], rd_busy[r]);
                end
            end
            tick();
            @(negedge clk);
        end
    endtask

    task automatic test_collision();
        idle();
        wr_en   = 2'b11;
        wr_addr = {5'd3, 5'd3};
        wr_data = {32'h12345678, 32'hDEADBEEF};
        tick();
        @(negedge clk);
        idle();
        rd_addr = {5'd3, 5'd3};
        #1;
        n_cmp++;
        if (rd_data[0] !== 32'h12345678 || rd_busy[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL collision data %h busy %b, need 12345678/0", rd_data[0], rd_busy[0]);
        end
        tick();
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        wr_en      = 2'b11;
        wr_addr    = '0;
        wr_data    = {32'hFFFFFFFF, 32'hFFFFFFFF};
        claim_en   = 1'b1;
        claim_addr = 5'd0;
        rd_addr    = '0;
        #1;
        n_cmp++;
        if (rd_data[0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL zero_same_cycle data %h busy %b, need 0/0", rd_data[0], rd_busy[0]);
        end
        tick();
        @(negedge clk);
        idle();
        #1;
        for (int r = 0; r < 2; r++) begin
            n_cmp++;
            if (rd_data[r] !== 32'h0 || rd_busy[r] !== 1'b0) begin
                n_mis++;
                $display("FAIL zero_after port%0d data %h busy %b, need 0/0", r, rd_data[r], rd_busy[r]);
            end
        end
        tick();
    endtask

    task automatic test_claim();
        @(negedge clk);
        idle();
        claim_en   = 1'b1;
        claim_addr = 5'd7;
        tick();
        @(negedge clk);
        idle();
        rd_addr = {5'd0, 5'd7};
        #1;
        n_cmp++;
        if (rd_busy[0] !== 1'b1) begin
            n_mis++;
            $display("FAIL claim_busy got %b, need 1", rd_busy[0]);
        end
        tick();
        @(negedge clk);
        wr_en[0]   = 1'b1;
        wr_addr[0] = 5'd7;
        wr_data[0] = 32'h55;
        tick();
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (rd_data[0] !== 32'h55 || rd_busy[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL writeback data %h busy %b, need 55/0", rd_data[0], rd_busy[0]);
        end
        wr_en[1]   = 1'b1;
        wr_addr[1] = 5'd7;
        wr_data[1] = 32'h66;
        claim_en   = 1'b1;
        claim_addr = 5'd7;
        tick();
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (rd_data[0] !== 32'h66 || rd_busy[0] !== 1'b1) begin
            n_mis++;
            $display("FAIL claim_wins data %h busy %b, need 66/1", rd_data[0], rd_busy[0]);
        end
        tick();
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        wr_en[0]   = 1'b1;
        wr_addr[0] = 5'd9;
        wr_data[0] = 32'h0BADF00D;
        tick();
        @(negedge clk);
        wr_data[0] = 32'hA5A5A5A5;
        rd_addr    = {5'd9, 5'd9};
        #1;
        n_cmp++;
`ifdef RF_BYPASS_EN
        if (rd_data[0] !== 32'hA5A5A5A5 || rd_busy[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL bypass_same data %h busy %b, need a5a5a5a5/0", rd_data[0], rd_busy[0]);
        end
`else
        if (rd_data[0] !== 32'h0BADF00D || rd_busy[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL nobypass_same data %h busy %b, need 0badf00d/0", rd_data[0], rd_busy[0]);
        end
`endif
        tick();
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (rd_data[1] !== 32'hA5A5A5A5) begin
            n_mis++;
            $display("FAIL write_next data %h, need a5a5a5a5", rd_data[1]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        idle();
        wr_en[0]   = 1'b1;
        wr_addr[0] = 5'd4;
        wr_data[0] = 32'h77;
        tick();
        @(negedge clk);
        idle();
        claim_en   = 1'b1;
        claim_addr = 5'd4;
        tick();
        @(negedge clk);
        idle();
        rd_addr = {5'd4, 5'd4};
        #1;
        n_cmp++;
        if (rd_data[0] !== 32'h77 || rd_busy[0] !== 1'b1) begin
            n_mis++;
            $display("FAIL pre_reset data %h busy %b, need 77/1", rd_data[0], rd_busy[0]);
        end
        reset      = 1'b1;
        wr_en[1]   = 1'b1;
        wr_addr[1] = 5'd4;
        wr_data[1] = 32'h99;
        claim_en   = 1'b1;
        claim_addr = 5'd4;
        #1;
        n_cmp++;
        if (rd_data[1] !== 32'h0 || rd_busy[1] !== 1'b0) begin
            n_mis++;
            $display("FAIL in_reset data %h busy %b, need 0/0", rd_data[1], rd_busy[1]);
        end
        tick();
        @(negedge clk);
        reset = 1'b0;
        idle();
        #1;
        n_cmp++;
        if (rd_data[0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
            n_mis++;
            $display("FAIL post_reset data %h busy %b, need 0/0", rd_data[0], rd_busy[0]);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            reset      = ($urandom_range(0, 49) == 0);
            wr_en      = 2'($urandom);
            wr_addr[0] = 5'($urandom_range(0, 7));
            wr_addr[1] = 5'($urandom_range(0, 7));
            wr_data    = {$urandom, $urandom};
            claim_en   = $urandom_range(0, 2) == 0;
            claim_addr = 5'($urandom_range(0, 7));
            rd_addr[0] = 5'($urandom_range(0, 8));
            rd_addr[1] = 5'($urandom_range(0, 31));
            #1;
            for (int r = 0; r < 2; r++) begin
                n_cmp++;
                if (rd_data[r] !== exp_data(r) || rd_busy[r] !== exp_busy(r)) begin
                    n_mis++;
                    $display("FAIL random c%0d port%0d addr %0d data %h busy %b, need %h/%b",
                             c, r, rd_addr[r], rd_data[r], rd_busy[r], exp_data(r), exp_busy(r));
                end
            end
            tick();
        end
        @(negedge clk);
        reset = 1'b0;
        idle();
    endtask

    initial begin
        rd_addr = '0;
        test_reset();
        test_collision();
        test_zero_reg();
        test_claim();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
